// File: rtl/muldiv_unit.sv
// muldiv_unit: multi-cycle multiply/divide unit with HI/LO result registers and a busy handshake.
// Define MULDIV_MADD_EN to enable madd/maddu (op 8/9); otherwise those codes are no-ops.
module muldiv_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic [3:0]       op,
   input  logic [WIDTH-1:0] numa,
   input  logic [WIDTH-1:0] numb,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, RUN} state_t;
   typedef enum logic [2:0] {K_MULT, K_MULTU, K_DIV, K_DIVU, K_MADD, K_MADDU} kind_t;

   state_t             state, state_d;
   kind_t              kind_q, kind_d;
   logic [CW-1:0]      cnt_q, lat_d;
   logic [WIDTH-1:0]   a_q, b_q;
   logic               long_op, accept, finish;
   logic               signed_op, a_neg, b_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, b_div, q_mag, r_mag;
   logic [2*WIDTH-1:0] a_ext, b_ext, product, result;

   // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      long_op = 1'b1;
      kind_d  = K_MULT;
      lat_d   = CW'(MULT_CYCLES);
      case (op)
         4'd1: kind_d = K_MULT;
         4'd2: kind_d = K_MULTU;
         4'd3: begin kind_d = K_DIV;  lat_d = CW'(DIV_CYCLES); end
         4'd4: begin kind_d = K_DIVU; lat_d = CW'(DIV_CYCLES); end
`ifdef MULDIV_MADD_EN
         4'd8: kind_d = K_MADD;
         4'd9: kind_d = K_MADDU;
`endif
         default: long_op = 1'b0;
      endcase
   end

   assign accept = (state == IDLE) && start && long_op;
   assign finish = (state == RUN) && (cnt_q == CW'(1));
   assign busy   = (state == RUN);

   always_comb begin
      state_d = state;
      case (state)
         IDLE:    if (accept) state_d = RUN;
         RUN:     if (finish) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_d;
   end

   // Result is formed from the latched operands at completion; madd reads HI/LO as held then.
   always_comb begin
      signed_op = (kind_q == K_MULT) || (kind_q == K_DIV) || (kind_q == K_MADD);
      a_ext     = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      b_ext     = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      product   = a_ext * b_ext;
      // Sign-magnitude divide: most-negative / -1 wraps back to most-negative with zero remainder.
      a_neg     = signed_op & a_q[WIDTH-1];
      b_neg     = signed_op & b_q[WIDTH-1];
      a_mag     = a_neg ? -a_q : a_q;
      b_mag     = b_neg ? -b_q : b_q;
      b_div     = (b_q == '0) ? WIDTH'(1) : b_mag;
      q_mag     = a_mag / b_div;
      r_mag     = a_mag % b_div;
      case (kind_q)
         K_DIV, K_DIVU: begin
            if (b_q == '0) result = {a_q, {WIDTH{1'b1}}};
            else           result = {(a_neg ? -r_mag : r_mag), ((a_neg ^ b_neg) ? -q_mag : q_mag)};
         end
         K_MADD, K_MADDU: result = {hi, lo} + product;
         default:         result = product;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q  <= '0;
         kind_q <= K_MULT;
         a_q    <= '0;
         b_q    <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= finish;
         if (accept) begin
            cnt_q  <= lat_d;
            kind_q <= kind_d;
            a_q    <= numa;
            b_q    <= numb;
         end else if (state == RUN) begin
            cnt_q <= cnt_q - CW'(1);
         end
         if (finish)                                  {hi, lo} <= result;
         else if (state == IDLE && start && op == 4'd5) hi      <= numa;
         else if (state == IDLE && start && op == 4'd6) lo      <= numa;
      end
   end
endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes expected HI/LO and latency, a monitor pops on done.
module tb_muldiv_unit;
   localparam int W  = 32;
   localparam int MC = 5;
   localparam int DC = 10;

   logic         clk, reset_n, start;
   logic [3:0]   op;
   logic [W-1:0] numa, numb;
   logic         busy, done;
   logic [W-1:0] hi, lo;

   muldiv_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk(clk), .reset_n(reset_n), .start(start), .op(op), .numa(numa), .numb(numb),
      .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] hilo;
      int          lat;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          checks = 0, failures = 0;
   int          cyc = 0, free_at = 0, run = 0, done_seen = 0;
   logic [31:0] m_hi = 0, m_lo = 0, vis_hi = 0, vis_lo = 0;
   bit          mon_en = 0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic bit is_long(input logic [3:0] o);
`ifdef MULDIV_MADD_EN
      return (o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9});
`else
      return (o inside {4'd1, 4'd2, 4'd3, 4'd4});
`endif
   endfunction

   // Reference arithmetic in 64-bit integers.
   function automatic logic [63:0] model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] h, input logic [31:0] l);
      longint          sa, sb_, q, r;
      longint unsigned ua, ub, uq, ur;
      sa = longint'(signed'(a));
      sb_ = longint'(signed'(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      case (o)
         4'd1: return sa * sb_;
         4'd2: return ua * ub;
         4'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            q = sa / sb_;
            r = sa % sb_;
            return {r[31:0], q[31:0]};
         end
         4'd4: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            uq = ua / ub;
            ur = ua % ub;
            return {ur[31:0], uq[31:0]};
         end
         4'd8:    return {h, l} + 64'(sa * sb_);
         4'd9:    return {h, l} + 64'(ua * ub);
         default: return {h, l};
      endcase
   endfunction

   // Called just after a rising edge; holds start for one cycle.
   task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      bit          acc;
      logic [63:0] e;
      acc   = (cyc >= free_at);
      start = 1'b1;
      op    = o;
      numa  = a;
      numb  = b;
      @(posedge clk); #1;
      start = 1'b0;
      op    = 4'($urandom);
      numa  = $urandom;
      numb  = $urandom;
      if (acc) begin
         if (is_long(o)) begin
            e = model(o, a, b, m_hi, m_lo);
            sb.push_back('{e, (o inside {4'd3, 4'd4}) ? DC : MC});
            {m_hi, m_lo} = e;
            free_at = cyc + ((o inside {4'd3, 4'd4}) ? DC : MC);
         end else if (o == 4'd5) begin
            m_hi = a; vis_hi = a;
         end else if (o == 4'd6) begin
            m_lo = a; vis_lo = a;
         end
      end
   endtask

   task automatic wait_idle();
      while (cyc < free_at) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic expect_hilo(input string name, input logic [31:0] h, input logic [31:0] l);
      wait_idle();
      @(negedge clk);
      check(name, {hi, lo}, {h, l});
      @(posedge clk); #1;
   endtask

   task automatic do_reset(input int n);
      reset_n = 1'b0;
      start   = 1'b0;
      @(posedge clk); #1;
      sb.delete();
      m_hi = 0; m_lo = 0; vis_hi = 0; vis_lo = 0;
      free_at = cyc;
      repeat (n - 1) begin @(posedge clk); #1; end
      reset_n = 1'b1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0:       return 32'd0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 9));
         default: return $urandom;
      endcase
   endfunction

   // Monitor: pops the scoreboard on done, checks busy length and that HI/LO never move otherwise.
   always @(negedge clk) begin
      if (mon_en && reset_n) begin
         if (done) begin
            done_seen++;
            if (sb.size() == 0) begin
               check("done_unexpected", 1, 0);
            end else begin
               mon_e = sb.pop_front();
               check("busy_len", 64'(run), 64'(mon_e.lat));
               check("result_hilo", {hi, lo}, mon_e.hilo);
               vis_hi = mon_e.hilo[63:32];
               vis_lo = mon_e.hilo[31:0];
            end
            run = 0;
         end else if (busy) begin
            run++;
         end else begin
            run = 0;
         end
         check("hilo_visible", {hi, lo}, {vis_hi, vis_lo});
      end
   end

   initial begin
      int          n0;
      logic [3:0]  ops[11];
      ops = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd0, 4'd7, 4'd15};
      reset_n = 1'b0; start = 1'b0; op = '0; numa = '0; numb = '0;
      do_reset(2);
      mon_en = 1;

      // Reset after arbitrary activity, including an in-flight mult.
      issue(4'd6, 32'h55, 0);
      issue(4'd5, 32'h66, 0);
      issue(4'd1, 32'd9, 32'd9);
      @(posedge clk); #1;
      do_reset(2);
      @(negedge clk);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_hi", hi, 0);
      check("reset_lo", lo, 0);
      @(posedge clk); #1;

      issue(4'd1, 32'hFFFF_FFFE, 32'd3); expect_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
      issue(4'd2, 32'hFFFF_FFFE, 32'd3); expect_hilo("multu",    32'h0000_0002, 32'hFFFF_FFFA);
      issue(4'd3, 32'hFFFF_FFF9, 32'd2); expect_hilo("div_neg",  32'hFFFF_FFFF, 32'hFFFF_FFFD);
      issue(4'd4, 32'd7, 32'd0);         expect_hilo("divu_by0", 32'h0000_0007, 32'hFFFF_FFFF);
      issue(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); expect_hilo("div_ovf", 32'h0, 32'h8000_0000);

      issue(4'd6, 32'h1234, 0);
      @(negedge clk);
      check("mtlo_lo", lo, 32'h1234);
      check("mtlo_busy", busy, 0);
      @(posedge clk); #1;

      // mthi and a second mult while busy are ignored.
      issue(4'd1, 32'd3, 32'd4);
      issue(4'd5, 32'hAAAA, 0);
      issue(4'd1, 32'd7, 32'd7);
      expect_hilo("mult_ignore", 32'h0, 32'd12);

      // Reset in cycle 3 of a div aborts it.
      issue(4'd3, 32'd100, 32'd7);
      repeat (2) begin @(posedge clk); #1; end
      n0 = done_seen;
      do_reset(1);
      @(negedge clk);
      check("abort_hilo", {hi, lo}, 64'd0);
      check("abort_busy", busy, 0);
      repeat (DC + 2) begin @(posedge clk); #1; end
      check("abort_no_done", 64'(done_seen), 64'(n0));

      // maddu accumulate, or no-op when the feature is absent.
      issue(4'd5, 32'h0, 0);
      issue(4'd6, 32'hFFFF_FFFF, 0);
      issue(4'd9, 32'd1, 32'd1);
      @(negedge clk);
`ifdef MULDIV_MADD_EN
      check("maddu_busy", busy, 1);
      @(posedge clk); #1;
      expect_hilo("maddu", 32'h1, 32'h0);
`else
      check("maddu_busy", busy, 0);
      @(posedge clk); #1;
      expect_hilo("maddu_noop", 32'h0, 32'hFFFF_FFFF);
`endif

      // Random traffic, sometimes issued while busy.
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0) wait_idle();
         issue(ops[$urandom_range(0, 10)], pick(), pick());
      end
      wait_idle();
      repeat (3) begin @(posedge clk); #1; end
      check("scoreboard_empty", 64'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
